// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MULT/MULTU/DIV/DIVU unit with start/busy/done handshake; MDU_EARLY_TERM_EN enables early multiply exit
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             state, state_nx;
    logic               load, step, write, calc_last;

    logic               is_div_q, neg_q, neg_r, dz_q;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   mq;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [CW-1:0]      count;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     shifted, diff;
    logic [2*WIDTH-1:0] div_next, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Operand magnitudes: -2^(W-1) maps to the same unsigned pattern, which is exact.
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;
    end

    // acc holds {remainder, quotient} for divide; mq holds the divisor during divide.
    always_comb begin
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, mq};
        div_next = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
        prod_fix = neg_q ? -acc : acc;
        quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        calc_last = (count == CW'(WIDTH - 1));
`ifdef MDU_EARLY_TERM_EN
        if (!is_div_q && ((mq >> 1) == '0))
            calc_last = 1'b1;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start && !cancel) state_nx = S_CALC;
            S_CALC:  if (cancel) state_nx = S_IDLE;
                     else if (calc_last) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == S_CALC) || (state == S_FIX);
        load  = (state == S_IDLE) && start && !cancel;
        step  = (state == S_CALC) && !cancel;
        write = (state == S_FIX) && !cancel;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_q        <= 1'b0;
            a_raw       <= '0;
            mq          <= '0;
            acc         <= '0;
            mcand       <= '0;
            count       <= '0;
        end else begin
            done <= write;
            if (load) begin
                is_div_q <= op[1];
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                dz_q     <= op[1] && (b == '0);
                a_raw    <= a;
                mq       <= mag_b;
                mcand    <= {{WIDTH{1'b0}}, mag_a};
                acc      <= op[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
                count    <= '0;
            end
            if (step) begin
                count <= count + 1'b1;
                if (is_div_q) begin
                    acc <= div_next;
                end else begin
                    if (mq[0])
                        acc <= acc + mcand;
                    mcand <= mcand << 1;
                    mq    <= mq >> 1;
                end
            end
            if (write) begin
                if (dz_q) begin
                    hi          <= a_raw;
                    lo          <= '1;
                    div_by_zero <= 1'b1;
                end else if (is_div_q) begin
                    hi          <= rem_fix;
                    lo          <= quot_fix;
                    div_by_zero <= 1'b0;
                end else begin
                    hi          <= prod_fix[2*WIDTH-1:WIDTH];
                    lo          <= prod_fix[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule
